// File: rtl/jt49_mave_mc_if.sv
// Sample stream and control bundle for the multi-channel moving averager.
// The master drives samples and window select; the slave returns averages.
interface jt49_mave_mc_if #(
  parameter int DW = 8,
  parameter int CW = 2
);
  logic          cen;
  logic [3:0]    wsel;
  logic          din_valid;
  logic [CW-1:0] din_ch;
  logic [DW-1:0] din;
  logic          busy;
  logic          dout_valid;
  logic [CW-1:0] dout_ch;
  logic [DW-1:0] dout;

  modport master (
    output cen, wsel, din_valid, din_ch, din,
    input  busy, dout_valid, dout_ch, dout
  );

  modport slave (
    input  cen, wsel, din_valid, din_ch, din,
    output busy, dout_valid, dout_ch, dout
  );
endinterface

// File: rtl/jt49_mave_mc.sv
// Time-multiplexed moving averager, CH channels sharing one delay-line RAM.
// Window 2^wact is run-time selectable; a flush zeroes RAM on reset/change.
module jt49_mave_mc #(
  parameter int DW   = 8,
  parameter int MAXD = 8,
  parameter int CH   = 4,
  parameter int CW   = 2
) (
  input logic clk,
  input logic rst,
  jt49_mave_mc_if.slave bus
);
  localparam int AW = $clog2(CH) + MAXD;
  localparam int SW = DW + MAXD + 1;

  typedef enum logic {CLEAR, RUN} st_t;

  st_t st;
  logic [3:0]    wact;
  logic [3:0]    wcl;
  logic          wchg;
  logic          acc;
  logic [AW-1:0] caddr;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          we;
  logic [MAXD-1:0] back;
  logic [MAXD-1:0] rpos;

  logic [MAXD-1:0]      ptr [CH];
  logic signed [SW-1:0] sum [CH];
  logic [DW-1:0]        ram [CH*(2**MAXD)];

  logic          s1_valid;
  logic [CW-1:0] s1_ch;
  logic [DW-1:0] s1_din;
  logic [AW-1:0] s1_waddr;
  logic          byp;
  logic [DW-1:0] byp_d;
  logic [DW-1:0] rdata;
  logic [DW-1:0] old;

  logic signed [DW:0]   diff;
  logic signed [SW-1:0] nsum;
  logic [DW-1:0]        dq;

  logic          busy_q;
  logic          dv_q;
  logic [CW-1:0] dch_q;
  logic [DW-1:0] dout_q;

  assign wcl  = bus.wsel > 4'(MAXD) ? 4'(MAXD) : bus.wsel;
  assign wchg = st == RUN && wcl != wact;
  assign acc  = bus.din_valid && st == RUN && !wchg;

  // oldest sample in the window sits 2^wact slots behind the write pointer
  assign back  = MAXD'(1 << wact);
  assign rpos  = ptr[bus.din_ch] - back;
  assign raddr = AW'({bus.din_ch, rpos});

  assign we    = st == CLEAR || s1_valid;
  assign waddr = st == CLEAR ? caddr : s1_waddr;
  assign wdata = st == CLEAR ? '0 : s1_din;

  assign old  = byp ? byp_d : rdata;
  assign diff = $signed({s1_din[DW-1], s1_din})
              - $signed({old[DW-1], old});
  assign nsum = sum[s1_ch] + SW'(diff);
  assign dq   = DW'(nsum >>> wact);

  // read-first RAM: a same-edge write never reaches the read data
  always_ff @(posedge clk) begin
    if (bus.cen) begin
      if (we)
        ram[waddr] <= wdata;
      rdata <= ram[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= CLEAR;
      caddr    <= '0;
      wact     <= wcl;
      busy_q   <= 1'b1;
      s1_valid <= 1'b0;
      byp      <= 1'b0;
      dv_q     <= 1'b0;
      dch_q    <= '0;
      dout_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        ptr[i] <= '0;
        sum[i] <= '0;
      end
    end else if (bus.cen) begin
      dv_q     <= 1'b0;
      s1_valid <= acc;
      byp      <= 1'b0;
      if (acc) begin
        s1_ch    <= bus.din_ch;
        s1_din   <= bus.din;
        s1_waddr <= AW'({bus.din_ch, ptr[bus.din_ch]});
        ptr[bus.din_ch] <= ptr[bus.din_ch] + 1'b1;
        byp      <= s1_valid && raddr == s1_waddr;
        byp_d    <= s1_din;
      end
      if (s1_valid) begin
        sum[s1_ch] <= nsum;
        dout_q     <= dq;
        dch_q      <= s1_ch;
        dv_q       <= !wchg;
      end
      unique case (st)
        CLEAR: begin
          caddr <= caddr + 1'b1;
          if (&caddr) begin
            st     <= RUN;
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (wchg) begin
            st       <= CLEAR;
            busy_q   <= 1'b1;
            caddr    <= '0;
            wact     <= wcl;
            s1_valid <= 1'b0;
            for (int i = 0; i < CH; i++) begin
              ptr[i] <= '0;
              sum[i] <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.dout_valid = dv_q;
  assign bus.dout_ch    = dch_q;
  assign bus.dout       = dout_q;
endmodule

// File: tb/tb_jt49_mave_mc.sv
// Directed and random checks of jt49_mave_mc against a window-history model.
// The model keeps the last 256 inputs per channel and floor-averages them.
module tb_jt49_mave_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jt49_mave_mc_if #(.DW(8), .CW(2)) bus();

  jt49_mave_mc #(
    .DW(8), .MAXD(8), .CH(4), .CW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int hist [4][256];
  int hpos [4];
  int mw;
  int bcnt;
  bit pv;
  int pch, pd;
  bit ev;
  int ech, ed;
  int gotv[$];
  int gotc[$];

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampw(input int w);
    return w > 8 ? 8 : w;
  endfunction

  function automatic int fdiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q--;
    return q;
  endfunction

  function automatic void clear_hist();
    for (int c = 0; c < 4; c++) begin
      hpos[c] = 0;
      for (int k = 0; k < 256; k++) hist[c][k] = 0;
    end
  endfunction

  // mean of the last 2^mw samples of channel ch, rounded toward -inf
  function automatic int model(input int ch, input int d);
    int s, n;
    s = 0;
    n = 1 << mw;
    hist[ch][hpos[ch]] = d;
    hpos[ch] = (hpos[ch] + 1) % 256;
    for (int k = 1; k <= n; k++)
      s += hist[ch][(hpos[ch] - k + 256) % 256];
    return fdiv(s, n);
  endfunction

  task automatic step(input bit c, input bit v,
                      input int ch, input int d);
    bit nv;
    int nch, nd;
    nv = 0;
    nch = 0;
    nd = 0;
    bus.cen = c;
    bus.din_valid = v;
    bus.din_ch = 2'(ch);
    bus.din = 8'(d);
    if (c) begin
      if (bcnt > 0) begin
        bcnt--;
      end else if (clampw(int'(bus.wsel)) != mw) begin
        mw = clampw(int'(bus.wsel));
        bcnt = 1024;
        clear_hist();
        pv = 0;
      end else if (v) begin
        nv = 1;
        nch = ch;
        nd = model(ch, d);
      end
      ev = pv;
      ech = pch;
      ed = pd;
      pv = nv;
      pch = nch;
      pd = nd;
    end
    @(posedge clk);
    #1;
    chk("busy", bus.busy, bcnt > 0);
    chk("dout_valid", bus.dout_valid, ev);
    if (ev) begin
      chk("dout", $signed(bus.dout), ed);
      chk("dout_ch", bus.dout_ch, ech);
    end
    if (c && bus.dout_valid === 1'b1) begin
      gotv.push_back(int'($signed(bus.dout)));
      gotc.push_back(int'(bus.dout_ch));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cen = 1'b1;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mw = clampw(int'(bus.wsel));
    bcnt = 1024;
    pv = 0;
    ev = 0;
    clear_hist();
    chk("rst_busy", bus.busy, 1);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout", $signed(bus.dout), 0);
    chk("rst_dout_ch", bus.dout_ch, 0);
  endtask

  // busy samples are counted from the DUT; random input is offered meanwhile
  task automatic wait_flush(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      n++;
      step(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)) - 128);
    end
    chk(tag, n, 1024);
  endtask

  task automatic new_window(input int w, input string tag);
    bus.wsel = 4'(w);
    step(1, 0, 0, 0);
    wait_flush(tag);
  endtask

  task automatic drain();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  initial begin
    int exp_step[5] = '{10, 20, 30, 40, 40};
    int exp_ind[8]  = '{-2, 40, -4, 40, -6, 40, -8, 40};
    int exp_byp[3]  = '{5, 7, -3};

    bus.cen = 1'b1;
    bus.wsel = 4'd2;
    bus.din_valid = 1'b0;
    bus.din_ch = '0;
    bus.din = '0;
    pch = 0;
    pd = 0;
    ech = 0;
    ed = 0;

    do_reset();
    wait_flush("reset_flush_len");

    gotv.delete();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 40);
    drain();
    for (int i = 0; i < 5; i++) chk("step_resp", gotv[i], exp_step[i]);

    gotv.delete();
    gotc.delete();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, -8);
      step(1, 1, 0, 40);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      chk("indep_val", gotv[i], exp_ind[i]);
      chk("indep_ch", gotc[i], (i % 2 == 0) ? 1 : 0);
    end

    new_window(1, "flush_w1");
    gotv.delete();
    step(1, 1, 2, -1);
    step(1, 1, 2, 0);
    drain();
    chk("floor_a", gotv[0], -1);
    chk("floor_b", gotv[1], -1);

    new_window(0, "flush_w0");
    gotv.delete();
    step(1, 1, 3, 5);
    step(1, 1, 3, 7);
    step(1, 1, 3, -3);
    drain();
    for (int i = 0; i < 3; i++) chk("bypass", gotv[i], exp_byp[i]);

    new_window(8, "flush_w8");
    gotv.delete();
    for (int i = 0; i < 256; i++) step(1, 1, 0, 100);
    for (int i = 0; i < 256; i++) step(1, 1, 0, 0);
    drain();
    chk("max_s256", gotv[255], 100);
    chk("max_s257", gotv[256], 99);
    chk("max_s512", gotv[511], 0);

    bus.wsel = 4'd12;
    for (int i = 0; i < 40; i++)
      step(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)) - 128);

    new_window(2, "flush_w2");
    for (int i = 0; i < 6; i++)
      step(1, 1, 0, int'($urandom_range(0, 255)) - 128);
    bus.wsel = 4'd3;
    step(1, 1, 0, 77);
    chk("chg_busy", bus.busy, 1);
    for (int i = 0; i < 300; i++)
      step(1, 1, int'($urandom_range(0, 3)), 55);
    do_reset();
    wait_flush("flush_mid_rst");
    gotv.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 16);
    drain();
    chk("restart_a", gotv[0], 2);
    chk("restart_b", gotv[7], 16);

    new_window(5, "flush_w5");
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)) - 128);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jt49_mave_mc.md
Name: jt49_mave_mc

Overview:
- Multi-channel, time-multiplexed moving averager for the PSG filter chain.
- Successor to the single-channel fixed-window averager, with these additions:
  - CH channels share one delay-line RAM.
  - The window length 2^wsel is selected at run time, up to 2^MAXD.
  - An explicit valid strobe and channel tag accompany each sample.
  - A self-clearing flush sequence runs on reset or on a window change.
- Sits between the channel mixer and the output interpolator. Samples arrive channel-serial.

Parameters:
- DW, 8, sample width (signed two's complement).
- MAXD, 8, log2 of the maximum window; RAM holds CH*2^MAXD words of DW bits.
- CH, 4, number of channels (power of two, at least 1).
- CW, 2, channel index width, equal to log2(CH) (1 when CH=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cen  in  1  clock enable. The pipeline and flush advance only when cen=1.
- wsel  in  4  log2 of the window, 0..MAXD. Values above MAXD are clamped to MAXD.
- din_valid  in  1  sample strobe, qualified by cen.
- din_ch  in  CW  channel of din.
- din  in  DW  signed input sample.
- busy  out  1  flush in progress; input is ignored while high.
- dout_valid  out  1  one-cycle (cen-qualified) output strobe.
- dout_ch  out  CW  channel of dout.
- dout  out  DW  signed averaged sample.

Behaviour:
- Reset is one clock, synchronous and active-high.
  - dout=0, dout_valid=0, dout_ch=0, busy=1.
  - All per-channel sums and pointers are cleared.
  - The FSM enters CLEAR, even if rst arrives mid-stream or mid-CLEAR. The clear address restarts at 0.
- FSM states are CLEAR and RUN.
  - CLEAR: one RAM word is written to 0 per cen cycle, addresses 0 .. CH*2^MAXD-1. After the last address, go to RUN on the next cen cycle and drop busy.
  - RUN: process samples.
  - RUN to CLEAR: the clamped wsel differs from the latched active window (wact). wact is loaded when CLEAR is entered.
- While busy=1:
  - din_valid is ignored and no dout_valid is produced.
  - Samples already in the pipeline are discarded.
- RAM address is {ch, pos}. Each channel has its own MAXD-bit write pointer ptr[ch], which wraps modulo 2^MAXD.
- Pipeline, accepted sample in cycle 0 (cen=1, din_valid=1, RUN):
  - Stage 0: issue a RAM read at {ch, ptr[ch] - 2^wact} (mod 2^MAXD). Register din and ch.
  - Stage 1: the read data is old.
    - diff = din - old, sign-extended to DW+1 bits.
    - sum[ch] <= sum[ch] + diff. Sums are DW+MAXD+1 bits, signed, one per channel.
    - Write din to {ch, ptr[ch]}; ptr[ch] <= ptr[ch] + 1.
  - Stage 2: dout = (new sum) >>> wact, arithmetic shift (floor), truncated to DW bits. dout_valid=1 and dout_ch=ch.
  - Latency is 2 cen-qualified cycles from accepted input to dout_valid.
- Read-first: when wact=MAXD, the read address equals the address being written. The stage-0 read must return the pre-write value. This holds because the write occurs in stage 1.
- Hazard bypass: when a same-channel sample is accepted in the cycle right after another, and its read address equals the stage-1 write address (wact=0), old is forwarded from the stage-1 write data rather than RAM. Different channels never conflict.
- The sum is exact. The window contains at most 2^MAXD samples of DW bits, so no overflow or saturation is possible.
- For wact=0, dout equals din delayed by 2.
- cen=0 freezes all state. din_valid is ignored while cen=0.

Test Plan:
- Reset flush:
  - Stimulus: CH=4, MAXD=8; pulse rst.
  - Response: busy high for exactly 1024 cen cycles, then low; no dout_valid meanwhile.
  - Stimulus: din_valid during busy.
  - Response: no output, and later averages are unaffected.
- Step response:
  - Stimulus: wsel=2, ch0 fed constant 40 every cycle.
  - Response: dout = 10, 20, 30, 40, 40, … with dout_valid 2 cycles after each input.
- Channel independence:
  - Stimulus: ch1 interleaved with ch0 at value -8.
  - Response: ch1 outputs -2, -4, -6, -8. ch0 output identical to the isolated run.
- Floor and edge windows:
  - Stimulus: wsel=1, inputs -1, 0.
  - Response: outputs -1, -1 (floor of -0.5).
  - Stimulus: wsel=0, back-to-back same channel 5, 7, -3.
  - Response: outputs 5, 7, -3 (bypass path).
- Maximum window:
  - Stimulus: wsel=8, 256 samples of 100, then 256 samples of 0.
  - Response: output reaches 100 at sample 256, then falls by 100/256 steps to 0 exactly at sample 512.
- Window change mid-stream:
  - Stimulus: change wsel 2 -> 3 while streaming.
  - Response: busy asserts on the next cen cycle, the in-flight sample produces no output, and after 1024 cycles averaging restarts from zero history.
